grid_access_arbiter: RTL and testbench

- Shares the single-port grid RAM (occupancy map, EMPTY = -1) among NREQ placement/evaluation engines using round-robin arbitration.
- Supports READ, WRITE and atomic CLAIM operations. CLAIM is read-check-write: write only if the cell holds EMPTY.
- Serialises all accesses so concurrent A/B walkers never double-occupy a cell.
- Sits between the placer FSMs and the grid memoryRAM instance.

---
 rtl/grid_access_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_grid_access_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/grid_access_arbiter.sv
// Round-robin arbiter serialising READ/WRITE/atomic CLAIM onto one grid RAM port; optional GRID_ARB_BOUNDS_CHECK_EN.
// One transaction in flight; requesters hold req until gnt; IDLE idles a cycle after every response.
module grid_access_arbiter #(
  parameter int NREQ       = 3,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int GRID_CELLS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  input  logic [DATA_W*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     claim_ok,
  output logic                     err,
  output logic                     busy,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_CLAIM = 2'd2;
  localparam logic [DATA_W-1:0] EMPTY = {DATA_W{1'b1}};
`ifdef GRID_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD_WAIT, CLAIM_WR, RESP} state_t;

  state_t              state_q, state_n;
  logic [IDX_W-1:0]    last_grant_q, last_grant_n;
  logic [IDX_W-1:0]    owner_q, owner_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                is_write_q, is_write_n;
  logic                is_claim_q, is_claim_n;
  logic                oob_q, oob_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;

  logic [NREQ-1:0]     gnt_n, rvalid_n;
  logic [DATA_W-1:0]   rdata_n, mem_din_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic                claim_ok_n, err_n, mem_re_n, mem_we_n;

  logic                win_vld;
  logic [IDX_W-1:0]    win;
  int                  idx;
  logic [1:0]          sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_oob;

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin scan starting just past the last winner
  always_comb begin
    win_vld = 1'b0;
    win     = last_grant_q;
    idx     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_grant_q) + i) % NREQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = IDX_W'(idx);
      end
    end
  end

  assign sel_op    = req_op[2*int'(win) +: 2];
  assign sel_addr  = req_addr[ADDR_W*int'(win) +: ADDR_W];
  assign sel_wdata = req_wdata[DATA_W*int'(win) +: DATA_W];
  assign sel_oob   = BOUNDS_EN && (32'(sel_addr) >= 32'(GRID_CELLS));

  always_comb begin
    state_n      = state_q;
    last_grant_n = last_grant_q;
    owner_n      = owner_q;
    cnt_n        = cnt_q;
    is_write_n   = is_write_q;
    is_claim_n   = is_claim_q;
    oob_n        = oob_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    gnt_n        = '0;
    rvalid_n     = '0;
    rdata_n      = '0;
    claim_ok_n   = 1'b0;
    err_n        = 1'b0;
    mem_re_n     = 1'b0;
    mem_we_n     = 1'b0;
    mem_addr_n   = '0;
    mem_din_n    = '0;

    unique case (state_q)
      IDLE: begin
        // rvalid still high means a response just left: keep one idle cycle
        if (win_vld && (rvalid == '0)) begin
          gnt_n        = onehot(win);
          last_grant_n = win;
          owner_n      = win;
          is_write_n   = (sel_op == OP_WRITE);
          is_claim_n   = (sel_op == OP_CLAIM);
          oob_n        = sel_oob;
          addr_n       = sel_addr;
          wdata_n      = sel_wdata;
          mem_addr_n   = sel_addr;
          cnt_n        = '0;
          if (sel_oob) begin
            state_n = RESP;
          end else if (sel_op == OP_WRITE) begin
            mem_we_n  = 1'b1;
            mem_din_n = sel_wdata;
            state_n   = RESP;
          end else begin
            mem_re_n = 1'b1;
            state_n  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MEM_LAT - 1)) state_n = RESP;
      end
      RESP: begin
        // For reads mem_dout is valid in this cycle
        if (!oob_q && is_claim_q && (mem_dout == EMPTY)) begin
          mem_we_n   = 1'b1;
          mem_addr_n = addr_q;
          mem_din_n  = wdata_q;
          state_n    = CLAIM_WR;
        end else begin
          rvalid_n = onehot(owner_q);
          state_n  = IDLE;
          if (oob_q) begin
            err_n   = 1'b1;
            rdata_n = EMPTY;
          end else if (!is_write_q) begin
            rdata_n = mem_dout;
          end
        end
      end
      CLAIM_WR: begin
        rvalid_n   = onehot(owner_q);
        rdata_n    = EMPTY;
        claim_ok_n = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NREQ - 1);
      owner_q      <= '0;
      cnt_q        <= '0;
      is_write_q   <= 1'b0;
      is_claim_q   <= 1'b0;
      oob_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      gnt          <= '0;
      rvalid       <= '0;
      rdata        <= '0;
      claim_ok     <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
    end else begin
      state_q      <= state_n;
      last_grant_q <= last_grant_n;
      owner_q      <= owner_n;
      cnt_q        <= cnt_n;
      is_write_q   <= is_write_n;
      is_claim_q   <= is_claim_n;
      oob_q        <= oob_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      gnt          <= gnt_n;
      rvalid       <= rvalid_n;
      rdata        <= rdata_n;
      claim_ok     <= claim_ok_n;
      err          <= err_n;
      busy         <= (state_n != IDLE);
      mem_re       <= mem_re_n;
      mem_we       <= mem_we_n;
      mem_addr     <= mem_addr_n;
      mem_din      <= mem_din_n;
    end
  end

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Directed bench for grid_access_arbiter with a 1-cycle-latency grid RAM model.
module tb_grid_access_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 12;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_op;
  logic [AW*NREQ-1:0] req_addr;
  logic [DW*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic              claim_ok, err, busy, mem_re, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din, mem_dout;

  logic [DW-1:0]     mem [0:(1<<AW)-1];
  logic              mem_clr;
  int                n_chk = 0;
  int                n_pass = 0;

  always #5 clk = ~clk;

  grid_access_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .GRID_CELLS(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .claim_ok(claim_ok), .err(err), .busy(busy), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= '1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_din;
      if (mem_re) mem_dout <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_op[2*r +: 2]     = op;
    req_addr[AW*r +: AW] = a;
    req_wdata[DW*r +: DW] = d;
    req[r]               = 1'b1;
  endtask

  // Waits (bounded) for any gnt, sampled on falling edges
  task automatic wait_gnt(input string tag, input logic [NREQ-1:0] exp);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gnt == '0 && k < 20);
    chk(tag, 32'(gnt), 32'(exp));
  endtask

  initial begin
    int gap;
    logic seen;
    reset = 1'b0; mem_clr = 1'b1;
    req = '0; req_op = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_ctl", {30'd0, mem_re, mem_we}, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b1; mem_clr = 1'b0;
    @(negedge clk);

    // WRITE addr 5 data 7 from requester 0
    set_req(0, 2'd1, 12'd5, 32'd7);
    wait_gnt("wr_gnt", 3'b001);
    req = '0;
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_addr", 32'(mem_addr), 5);
    chk("wr_din", mem_din, 7);
    chk("wr_re", 32'(mem_re), 0);
    chk("wr_busy", 32'(busy), 1);
    @(negedge clk);
    chk("wr_rvalid", 32'(rvalid), 3'b001);
    chk("wr_claim_ok", 32'(claim_ok), 0);
    chk("wr_rdata", rdata, 0);
    chk("wr_mem", mem[5], 7);
    repeat (2) @(negedge clk);

    // Successful CLAIM on an empty cell
    mem_clr = 1'b1; @(negedge clk); mem_clr = 1'b0;
    set_req(1, 2'd2, 12'd5, 32'd3);
    wait_gnt("cl_gnt", 3'b010);
    req = '0;
    chk("cl_re", 32'(mem_re), 1);
    chk("cl_addr", 32'(mem_addr), 5);
    @(negedge clk);
    chk("cl_g1_we", {30'd0, mem_we, |rvalid}, 0);
    @(negedge clk);
    chk("cl_we", 32'(mem_we), 1);
    chk("cl_din", mem_din, 3);
    chk("cl_rvalid_early", 32'(rvalid), 0);
    @(negedge clk);
    chk("cl_rvalid", 32'(rvalid), 3'b010);
    chk("cl_ok", 32'(claim_ok), 1);
    chk("cl_rdata", rdata, 32'hFFFF_FFFF);
    chk("cl_mem", mem[5], 3);
    repeat (2) @(negedge clk);

    // Failed CLAIM on an occupied cell
    set_req(2, 2'd2, 12'd5, 32'd9);
    wait_gnt("clf_gnt", 3'b100);
    req = '0;
    @(negedge clk);
    chk("clf_g1", {30'd0, mem_we, |rvalid}, 0);
    @(negedge clk);
    chk("clf_rvalid", 32'(rvalid), 3'b100);
    chk("clf_ok", 32'(claim_ok), 0);
    chk("clf_rdata", rdata, 3);
    chk("clf_we", 32'(mem_we), 0);
    chk("clf_mem", mem[5], 3);
    repeat (2) @(negedge clk);

    // Reserved op 3 behaves as READ
    set_req(1, 2'd3, 12'd5, 32'd55);
    wait_gnt("op3_gnt", 3'b010);
    req = '0;
    chk("op3_ctl", {30'd0, mem_re, mem_we}, 2'b10);
    repeat (2) @(negedge clk);
    chk("op3_rvalid", 32'(rvalid), 3'b010);
    chk("op3_rdata", rdata, 3);
    repeat (2) @(negedge clk);

    // All three READ held high: rotation 0,1,2,0,1,2 (last grant was 1)
    set_req(0, 2'd0, 12'd0, 32'd0);
    set_req(1, 2'd0, 12'd5, 32'd0);
    set_req(2, 2'd0, 12'd2, 32'd0);
    wait_gnt("rr_g0", 3'b100);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      logic [NREQ-1:0] e;
      e = 3'b001 << (i % 3);
      wait_gnt($sformatf("rr_g%0d", i + 1), e);
      repeat (2) @(negedge clk);
      chk($sformatf("rr_rv%0d", i + 1), 32'(rvalid), 32'(e));
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Back-to-back WRITEs held high: three cycles issue-to-issue
    set_req(0, 2'd1, 12'd8, 32'd1);
    wait_gnt("b2b_g1", 3'b001);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (gnt == '0 && gap < 10);
    req = '0;
    chk("b2b_gap", 32'(gap), 3);
    repeat (3) @(negedge clk);

    // Reset during RD_WAIT of a CLAIM
    set_req(1, 2'd2, 12'd7, 32'd4);
    wait_gnt("rc_gnt", 3'b010);
    req = '0;
    reset = 1'b0;
    #1;
    chk("rc_out", {27'd0, busy, mem_re, mem_we, |gnt, |rvalid}, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | mem_we | (|rvalid);
    end
    chk("rc_quiet", 32'(seen), 0);
    chk("rc_mem", mem[7], 32'hFFFF_FFFF);
    set_req(0, 2'd0, 12'd1, 32'd0);
    set_req(1, 2'd0, 12'd1, 32'd0);
    set_req(2, 2'd0, 12'd1, 32'd0);
    wait_gnt("rc_next", 3'b001);
    req = '0;
    repeat (4) @(negedge clk);

    // Address 16 vs 15
    set_req(2, 2'd0, 12'd16, 32'd0);
    wait_gnt("b16_gnt", 3'b100);
    req = '0;
`ifdef GRID_ARB_BOUNDS_CHECK_EN
    chk("b16_re", 32'(mem_re), 0);
    @(negedge clk);
    chk("b16_rvalid", 32'(rvalid), 3'b100);
    chk("b16_err", 32'(err), 1);
    chk("b16_rdata", rdata, 32'hFFFF_FFFF);
`else
    chk("b16_re", 32'(mem_re), 1);
    repeat (2) @(negedge clk);
    chk("b16_rvalid", 32'(rvalid), 3'b100);
    chk("b16_err", 32'(err), 0);
`endif
    repeat (3) @(negedge clk);
    set_req(0, 2'd0, 12'd15, 32'd0);
    wait_gnt("b15_gnt", 3'b001);
    req = '0;
    chk("b15_re", 32'(mem_re), 1);
    repeat (2) @(negedge clk);
    chk("b15_rvalid", 32'(rvalid), 3'b001);
    chk("b15_err", 32'(err), 0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
